// File: rtl/mips_core_pkg.sv
// Shared core definitions: ROB sizing and the entry record used by the
// reorder buffer, rename and issue.
package mips_core_pkg;

    localparam int ROB_DEPTH      = 16;
    localparam int ROB_DEPTH_BITS = 4;

    // Count value meaning "every entry occupied".
    localparam logic [ROB_DEPTH_BITS:0] ROB_FULL_CNT = (ROB_DEPTH_BITS+1)'(ROB_DEPTH);

    typedef struct packed {
        logic        valid;
        logic        done;
        logic        uses_rw;
        logic [4:0]  rw_addr;
        logic [5:0]  rw_phy;
        logic [31:0] data;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates at tail, completes by tag,
// retires at most one done head entry per cycle with registered outputs.
import mips_core_pkg::*;

module reorder_buffer (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_alloc_valid,
    input  logic                      i_alloc_uses_rw,
    input  logic [4:0]                i_alloc_rw_addr,
    input  logic [5:0]                i_alloc_rw_phy,
    output logic                      o_alloc_ready,
    output logic [ROB_DEPTH_BITS-1:0] o_alloc_tag,
    input  logic                      i_wb_valid,
    input  logic [ROB_DEPTH_BITS-1:0] i_wb_tag,
    input  logic [31:0]               i_wb_data,
    input  logic                      i_flush,
    output logic                      o_commit_en,
    output logic [4:0]                o_commit_addr,
    output logic [5:0]                o_commit_phy,
    output logic [31:0]               o_commit_data,
    output logic                      o_retire,
    output logic                      o_empty,
    output logic [ROB_DEPTH_BITS:0]   o_count
);

    rob_entry_t                r_rob [ROB_DEPTH];
    logic [ROB_DEPTH_BITS-1:0] r_head;
    logic [ROB_DEPTH_BITS-1:0] r_tail;
    logic [ROB_DEPTH_BITS:0]   r_count;
    logic                      r_commit_en;
    logic                      r_retire;
    logic [4:0]                r_commit_addr;
    logic [5:0]                r_commit_phy;
    logic [31:0]               r_commit_data;

    rob_entry_t w_head_ent;
    logic       w_alloc_fire;
    logic       w_wb_fire;
    logic       w_retire_fire;
    logic       w_commit_fire;

    // Fire decisions for this cycle; flush suppresses all of them.
    always_comb begin
        w_head_ent    = r_rob[r_head];
        w_alloc_fire  = i_alloc_valid && (r_count != ROB_FULL_CNT) && !i_flush;
        w_wb_fire     = i_wb_valid && r_rob[i_wb_tag].valid && !i_flush;
        w_retire_fire = w_head_ent.valid && w_head_ent.done && !i_flush;
        // Writes to $zero are architecturally invisible, so they only retire.
        w_commit_fire = w_retire_fire && w_head_ent.uses_rw && (w_head_ent.rw_addr != 5'd0);
    end

    // Entry storage, pointers, occupancy and registered retire outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                r_rob[i].valid <= 1'b0;
                r_rob[i].done  <= 1'b0;
            end
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_commit_en <= 1'b0;
            r_retire    <= 1'b0;
            if (i_rst) begin
                for (int i = 0; i < ROB_DEPTH; i++) begin
                    r_rob[i] <= '0;
                end
                r_commit_addr <= '0;
                r_commit_phy  <= '0;
                r_commit_data <= '0;
            end
        end else begin
            // Retire first so a same-index writeback or alloc below wins;
            // neither can legally target the retiring head anyway.
            if (w_retire_fire) begin
                r_rob[r_head].valid <= 1'b0;
                r_head              <= r_head + 1'b1;
            end
            if (w_wb_fire) begin
                r_rob[i_wb_tag].done <= 1'b1;
                r_rob[i_wb_tag].data <= i_wb_data;
            end
            if (w_alloc_fire) begin
                r_rob[r_tail].valid   <= 1'b1;
                r_rob[r_tail].done    <= 1'b0;
                r_rob[r_tail].uses_rw <= i_alloc_uses_rw;
                r_rob[r_tail].rw_addr <= i_alloc_rw_addr;
                r_rob[r_tail].rw_phy  <= i_alloc_rw_phy;
                r_rob[r_tail].data    <= '0;
                r_tail                <= r_tail + 1'b1;
            end
            case ({w_alloc_fire, w_retire_fire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_retire    <= w_retire_fire;
            r_commit_en <= w_commit_fire;
            // Commit payload holds between commits.
            if (w_commit_fire) begin
                r_commit_addr <= w_head_ent.rw_addr;
                r_commit_phy  <= w_head_ent.rw_phy;
                r_commit_data <= w_head_ent.data;
            end
        end
    end

    // Status outputs decode straight from state.
    always_comb begin
        o_alloc_ready = (r_count != ROB_FULL_CNT);
        o_alloc_tag   = r_tail;
        o_empty       = (r_count == '0);
        o_count       = r_count;
        o_commit_en   = r_commit_en;
        o_retire      = r_retire;
        o_commit_addr = r_commit_addr;
        o_commit_phy  = r_commit_phy;
        o_commit_data = r_commit_data;
    end

endmodule
